multi_step_counter: RTL and testbench

- Parametrised bank of NUM_CH free-running step counters. Each channel has its own runtime-programmable step, enable, clear, and wrap/saturate mode, plus sticky overflow.
- A snapshot port captures all counts atomically behind a valid/ready handshake.
- Serves as the stimulus/DUT counter source for VPI and HSE example tops. It drives per-channel and concatenated count buses into probe sub-instances.

---
 rtl/msc_pkg.sv | 18 +
 rtl/step_counter_ch.sv | 69 ++++++
 rtl/multi_step_counter.sv | 84 ++++++++
 tb/tb_multi_step_counter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/msc_pkg.sv
// Shared types and helpers for the multi-channel step counter bank.
package msc_pkg;

  localparam int MSC_MAX_CH    = 16;
  localparam int MSC_MIN_WIDTH = 2;
  localparam int MSC_MAX_WIDTH = 64;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Reset step of channel i; callers truncate to their step width.
  function automatic int unsigned def_step(input int i);
    return int'(i) + 1;
  endfunction

endpackage

// File: rtl/step_counter_ch.sv
// One counter channel: programmable step, wrap/saturate mode,
// synchronous clear and sticky overflow.
module step_counter_ch
  import msc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8,
  parameter logic [STEP_W-1:0] DEF_STEP = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              cfg_sat,
  output logic [WIDTH-1:0]  count,
  output logic              ovf
);

  logic [WIDTH-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [STEP_W-1:0] step_q, step_d;
  mode_e             mode_q, mode_d;
  logic [WIDTH:0]    sum;

  assign sum = {1'b0, count_q} + (WIDTH+1)'(step_q);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    step_d  = step_q;
    mode_d  = mode_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en) begin
      count_d = sum[WIDTH-1:0];
      if (sum[WIDTH]) begin
        ovf_d = 1'b1;
        if (mode_q == MODE_SAT)
          count_d = '1;
      end
    end
    // New step/mode take effect only from the following cycle.
    if (cfg_we) begin
      step_d = cfg_step;
      mode_d = cfg_sat ? MODE_SAT : MODE_WRAP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      step_q  <= DEF_STEP;
      mode_q  <= MODE_WRAP;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/multi_step_counter.sv
// Bank of NUM_CH step counters with config decode and an
// atomic valid/ready snapshot of all counts.
module multi_step_counter
  import msc_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic                    cfg_valid,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [STEP_W-1:0]       cfg_step,
  input  logic                    cfg_sat,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       ovf,
  input  logic                    snap_req,
  output logic                    snap_valid,
  input  logic                    snap_ready,
  output logic [NUM_CH*WIDTH-1:0] snap_data
);

  logic                    cfg_in_range;
  logic [NUM_CH-1:0]       cfg_we;
  logic                    snap_cap;
  logic                    snap_valid_q, snap_valid_d;
  logic [NUM_CH*WIDTH-1:0] snap_data_q, snap_data_d;

  assign cfg_in_range = int'(cfg_ch) < NUM_CH;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_we[i] = cfg_valid && cfg_in_range
                       && (int'(cfg_ch) == i);

    step_counter_ch #(
      .WIDTH   (WIDTH),
      .STEP_W  (STEP_W),
      .DEF_STEP(STEP_W'(def_step(i)))
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .clr     (clr[i]),
      .cfg_we  (cfg_we[i]),
      .cfg_step(cfg_step),
      .cfg_sat (cfg_sat),
      .count   (count[i*WIDTH +: WIDTH]),
      .ovf     (ovf[i])
    );
  end

  // Capture the pre-update counts; drop requests while a
  // snapshot is outstanding and not being consumed.
  assign snap_cap = snap_req && (!snap_valid_q || snap_ready);

  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    if (snap_cap) begin
      snap_valid_d = 1'b1;
      snap_data_d  = count;
    end else if (snap_ready) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;

endmodule

// File: tb/tb_multi_step_counter.sv
// Directed bench for multi_step_counter (NUM_CH=3, WIDTH=8).
module tb_multi_step_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  en, clr;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_step;
  logic        cfg_sat;
  logic [23:0] count;
  logic [2:0]  ovf;
  logic        snap_req, snap_valid, snap_ready;
  logic [23:0] snap_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] en;
    logic [2:0] clr;
    logic       cv;
    logic [1:0] ch;
    logic [7:0] step;
    logic       sat;
    logic [7:0] c0, c1, c2;
    logic [2:0] ovf;
  } vec_t;

  vec_t tbl[$];

  multi_step_counter dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_step  (cfg_step),
    .cfg_sat   (cfg_sat),
    .count     (count),
    .ovf       (ovf),
    .snap_req  (snap_req),
    .snap_valid(snap_valid),
    .snap_ready(snap_ready),
    .snap_data (snap_data)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pk(
    input logic [7:0] c0, c1, c2);
    return {c2, c1, c0};
  endfunction

  function automatic vec_t mk(
    input logic [2:0] e, c, input logic v,
    input logic [1:0] ch, input logic [7:0] st,
    input logic s, input logic [7:0] a, b, d,
    input logic [2:0] o);
    vec_t r;
    r.en = e; r.clr = c; r.cv = v; r.ch = ch;
    r.step = st; r.sat = s;
    r.c0 = a; r.c1 = b; r.c2 = d; r.ovf = o;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 3'b000; clr = 3'b000;
    cfg_valid = 1'b0; cfg_ch = 2'd0;
    cfg_step = 8'd0; cfg_sat = 1'b0;
    snap_req = 1'b0; snap_ready = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_sv", 64'(snap_valid), 64'd0);
    chk("rst_sd", 64'(snap_data), 64'd0);
    reset = 1'b0;

    // Default steps 1,2,3 and wrap on channel 2
    en = 3'b111;
    for (int i = 1; i <= 86; i++) begin
      tick();
      if (i == 10) begin
        chk("def10_count", 64'(count), 64'(pk(10, 20, 30)));
        chk("def10_ovf", 64'(ovf), 64'd0);
      end
      if (i == 85) begin
        chk("pre_wrap_count", 64'(count), 64'(pk(85, 170, 255)));
        chk("pre_wrap_ovf", 64'(ovf), 64'd0);
      end
    end
    chk("wrap_count", 64'(count), 64'(pk(86, 172, 2)));
    chk("wrap_ovf", 64'(ovf), 64'b100);

    en = 3'b000; clr = 3'b111;
    tick();
    chk("clr_all_count", 64'(count), 64'd0);
    chk("clr_all_ovf", 64'(ovf), 64'd0);
    clr = 3'b000;

    // en clr cv ch step sat | c0 c1 c2 ovf
    tbl.push_back(mk(3'b000, 3'b000, 1, 1, 100, 1,   0,   0, 0, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 0, 0,   0, 0,   0, 100, 0, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 0, 0,   0, 0,   0, 200, 0, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 0, 0,   0, 0,   0, 255, 0, 3'b010));
    tbl.push_back(mk(3'b010, 3'b000, 0, 0,   0, 0,   0, 255, 0, 3'b010));
    tbl.push_back(mk(3'b010, 3'b010, 0, 0,   0, 0,   0,   0, 0, 3'b000));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(3'b001, 3'b000, 0, 0, 0, 0,
                       8'(k), 0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 1, 0,   5, 0,   8,   0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 0, 0,   0, 0,  13,   0, 0, 3'b000));
    tbl.push_back(mk(3'b000, 3'b000, 1, 3,  50, 1,  13,   0, 0, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000, 0, 0,   0, 0,  18, 100, 3, 3'b000));
    tbl.push_back(mk(3'b000, 3'b000, 1, 2,   0, 0,  18, 100, 3, 3'b000));
    tbl.push_back(mk(3'b100, 3'b000, 0, 0,   0, 0,  18, 100, 3, 3'b000));

    foreach (tbl[k]) begin
      en = tbl[k].en; clr = tbl[k].clr;
      cfg_valid = tbl[k].cv; cfg_ch = tbl[k].ch;
      cfg_step = tbl[k].step; cfg_sat = tbl[k].sat;
      tick();
      chk($sformatf("vec%0d_count", k), 64'(count),
          64'(pk(tbl[k].c0, tbl[k].c1, tbl[k].c2)));
      chk($sformatf("vec%0d_ovf", k), 64'(ovf),
          64'(tbl[k].ovf));
    end
    idle();

    // Snapshot handshake from fresh defaults
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en = 3'b111;
    tick(); tick(); tick();
    chk("snap_pre_count", 64'(count), 64'(pk(3, 6, 9)));
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("snap_cap_valid", 64'(snap_valid), 64'd1);
    chk("snap_cap_data", 64'(snap_data), 64'(pk(3, 6, 9)));
    for (int c = 0; c < 4; c++) begin
      snap_req = (c == 1);
      tick();
      chk($sformatf("snap_hold%0d_v", c), 64'(snap_valid), 64'd1);
      chk($sformatf("snap_hold%0d_d", c), 64'(snap_data),
          64'(pk(3, 6, 9)));
    end
    snap_req = 1'b0;
    en = 3'b000; snap_ready = 1'b1;
    tick();
    chk("snap_rel_valid", 64'(snap_valid), 64'd0);
    chk("snap_run_count", 64'(count), 64'(pk(8, 16, 24)));
    snap_ready = 1'b0; snap_req = 1'b1;
    tick();
    chk("snap2_data", 64'(snap_data), 64'(pk(8, 16, 24)));
    snap_req = 1'b0; en = 3'b111;
    tick();
    en = 3'b000; snap_req = 1'b1; snap_ready = 1'b1;
    tick();
    chk("snap_b2b_valid", 64'(snap_valid), 64'd1);
    chk("snap_b2b_data", 64'(snap_data), 64'(pk(9, 18, 27)));
    snap_req = 1'b0;
    tick();
    chk("snap_b2b_rel", 64'(snap_valid), 64'd0);
    snap_ready = 1'b0;

    // Asynchronous reset with a pending snapshot
    clr = 3'b111;
    tick();
    clr = 3'b000;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_step = 8'd200;
    tick();
    cfg_valid = 1'b0;
    en = 3'b100;
    tick();
    en = 3'b000; snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("pre_rst_count", 64'(count), 64'(pk(0, 0, 200)));
    chk("pre_rst_sv", 64'(snap_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_sv", 64'(snap_valid), 64'd0);
    chk("async_sd", 64'(snap_data), 64'd0);
    chk("async_ovf", 64'(ovf), 64'd0);
    tick();
    reset = 1'b0;
    en = 3'b111;
    tick();
    chk("post_rst_steps", 64'(count), 64'(pk(1, 2, 3)));
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
